// File: rtl/xmit_traffic_gen_if.sv
// Transmit-side frame bus between the traffic generator and the transmit subsystem.
interface xmit_traffic_gen_if #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 12
);
   logic [DATA_W-1:0]  f_data_in;
   logic [2*LEN_W-1:0] f_ctrl_in;
   logic               f_rec_data_valid;
   logic               f_rec_frame_valid;
   logic               f_hi_priority;

   modport master (
      output f_data_in,
      output f_ctrl_in,
      output f_rec_data_valid,
      output f_rec_frame_valid,
      output f_hi_priority
   );

   modport slave (
      input f_data_in,
      input f_ctrl_in,
      input f_rec_data_valid,
      input f_rec_frame_valid,
      input f_hi_priority
   );
endinterface

// File: rtl/xmit_traffic_gen.sv
// Frame traffic generator: emits runs of hi/lo priority frames (header + body),
// separated by idle gaps, with per-class incrementing payload bytes.
module xmit_traffic_gen #(
   parameter int               DATA_W    = 8,
   parameter int               LEN_W     = 12,
   parameter int               HI_PER_LO = 10,
   parameter int               IFG       = 1,
   parameter logic [DATA_W-1:0] HI_SEED  = 8'hF0,
   parameter logic [DATA_W-1:0] LO_SEED  = 8'h00
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               start,
   input  logic               hold,
   input  logic [LEN_W-1:0]   cfg_hi_len,
   input  logic [LEN_W-1:0]   cfg_lo_len,
   input  logic [15:0]        cfg_num_frames,
   xmit_traffic_gen_if.master tx,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {IDLE, HDR, BODY, GAP} state_t;

   // Gap counter is loaded with the number of gap cycles still to go after the first one.
   localparam logic [15:0] GAP_LOAD = (IFG > 0) ? 16'(IFG - 1) : 16'd0;
   localparam logic [15:0] HPL      = 16'(HI_PER_LO);

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    hi_len_q, hi_len_d;
   logic [LEN_W-1:0]    lo_len_q, lo_len_d;
   logic [15:0]         num_q, num_d;
   logic [LEN_W-1:0]    remain_q, remain_d;    // data cycles left after the current one
   logic [15:0]         gap_q, gap_d;          // gap cycles left; 0 = waiting for hold release
   logic [15:0]         seq_q, seq_d;          // hi frames sent since the last lo frame
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic [DATA_W-1:0]   hi_cnt_q, hi_cnt_d;
   logic [DATA_W-1:0]   lo_cnt_q, lo_cnt_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [2*LEN_W-1:0]  ctrl_q, ctrl_d;
   logic                dv_q, dv_d;
   logic                fv_q, fv_d;
   logic                hp_q, hp_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                launch;
   logic                next_hi;
   logic [LEN_W-1:0]    len;

   // Next-state and next-output decode; outputs are registered alongside the state.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d     = state_q;
      hi_len_d    = hi_len_q;
      lo_len_d    = lo_len_q;
      num_d       = num_q;
      remain_d    = remain_q;
      gap_d       = gap_q;
      seq_d       = seq_q;
      frame_cnt_d = frame_cnt_q;
      hi_cnt_d    = hi_cnt_q;
      lo_cnt_d    = lo_cnt_q;
      data_d      = data_q;
      hp_d        = hp_q;
      busy_d      = busy_q;
      ctrl_d      = '0;
      dv_d        = 1'b0;
      fv_d        = 1'b0;
      done_d      = 1'b0;
      launch      = 1'b0;
      next_hi     = 1'b0;
      len         = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               hi_len_d    = cfg_hi_len;
               lo_len_d    = cfg_lo_len;
               num_d       = cfg_num_frames;
               seq_d       = '0;
               frame_cnt_d = '0;
               busy_d      = 1'b1;
               if (!hold) begin
                  launch = 1'b1;
               end else begin
                  // Armed: park in GAP with nothing left to count until hold drops.
                  state_d = GAP;
                  gap_d   = '0;
               end
            end
         end
         HDR, BODY: begin
            if (remain_q == '0) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               if (hp_q) begin
                  hi_cnt_d = hi_cnt_q + DATA_W'(1);
                  seq_d    = seq_q + 16'd1;
               end else begin
                  lo_cnt_d = lo_cnt_q + DATA_W'(1);
                  seq_d    = '0;
               end
               if (num_q != '0 && frame_cnt_d == num_q) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else if (IFG > 0) begin
                  state_d = GAP;
                  gap_d   = GAP_LOAD;
               end else if (!hold) begin
                  launch = 1'b1;
               end else begin
                  state_d = GAP;
                  gap_d   = '0;
               end
            end else begin
               state_d  = BODY;
               remain_d = remain_q - LEN_W'(1);
               dv_d     = 1'b1;
            end
         end
         GAP: begin
            if (gap_q != '0) begin
               gap_d = gap_q - 16'd1;
            end else if (!hold) begin
               launch = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Header of a new frame; uses the freshly updated counters and latched lengths.
      if (launch) begin
         next_hi  = (HI_PER_LO > 0) && (seq_d < HPL);
         len      = next_hi ? hi_len_d : lo_len_d;
         state_d  = HDR;
         fv_d     = 1'b1;
         dv_d     = 1'b1;
         ctrl_d   = {len, len};
         data_d   = next_hi ? hi_cnt_d : lo_cnt_d;
         hp_d     = next_hi;
         // A zero length still sends the header cycle, so it behaves as length 1.
         remain_d = (len == '0) ? '0 : len - LEN_W'(1);
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_sys) begin
      // NOTE: reset clears every register here, including the latched config, so a
      // reset mid-frame leaves no stale state behind.
      if (reset) begin
         state_q     <= IDLE;
         hi_len_q    <= '0;
         lo_len_q    <= '0;
         num_q       <= '0;
         remain_q    <= '0;
         gap_q       <= '0;
         seq_q       <= '0;
         frame_cnt_q <= '0;
         hi_cnt_q    <= HI_SEED;
         lo_cnt_q    <= LO_SEED;
         data_q      <= '0;
         ctrl_q      <= '0;
         dv_q        <= 1'b0;
         fv_q        <= 1'b0;
         hp_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking so all registers update together from the same decode.
         state_q     <= state_d;
         hi_len_q    <= hi_len_d;
         lo_len_q    <= lo_len_d;
         num_q       <= num_d;
         remain_q    <= remain_d;
         gap_q       <= gap_d;
         seq_q       <= seq_d;
         frame_cnt_q <= frame_cnt_d;
         hi_cnt_q    <= hi_cnt_d;
         lo_cnt_q    <= lo_cnt_d;
         data_q      <= data_d;
         ctrl_q      <= ctrl_d;
         dv_q        <= dv_d;
         fv_q        <= fv_d;
         hp_q        <= hp_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign tx.f_data_in         = data_q;
   assign tx.f_ctrl_in         = ctrl_q;
   assign tx.f_rec_data_valid  = dv_q;
   assign tx.f_rec_frame_valid = fv_q;
   assign tx.f_hi_priority     = hp_q;
   assign busy                 = busy_q;
   assign done                 = done_q;

endmodule

// File: tb/tb_xmit_traffic_gen.sv
// Self-checking bench: three generator instances with different class mixes and
// gaps share one stimulus stream; a frame-level model predicts every output cycle.
module tb_xmit_traffic_gen;

   localparam int         N = 3;
   localparam int         P_HPL [N] = '{10, 0, 5};
   localparam int         P_IFG [N] = '{1, 0, 3};
   localparam logic [7:0] P_HS  [N] = '{8'hF0, 8'hF0, 8'hFE};
   localparam logic [7:0] P_LS  [N] = '{8'h00, 8'h00, 8'h80};

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        start;
   logic        hold;
   logic [11:0] cfg_hi_len;
   logic [11:0] cfg_lo_len;
   logic [15:0] cfg_num_frames;
   logic        busy_s [N];
   logic        done_s [N];

   int n_checks;
   int n_pass;

   always #5 clk_sys = ~clk_sys;

   xmit_traffic_gen_if bus0 ();
   xmit_traffic_gen_if bus1 ();
   xmit_traffic_gen_if bus2 ();

   xmit_traffic_gen #(.HI_PER_LO(P_HPL[0]), .IFG(P_IFG[0]), .HI_SEED(P_HS[0]), .LO_SEED(P_LS[0])) dut0 (
      .clk_sys(clk_sys), .reset(reset), .start(start), .hold(hold),
      .cfg_hi_len(cfg_hi_len), .cfg_lo_len(cfg_lo_len), .cfg_num_frames(cfg_num_frames),
      .tx(bus0), .busy(busy_s[0]), .done(done_s[0]));

   xmit_traffic_gen #(.HI_PER_LO(P_HPL[1]), .IFG(P_IFG[1]), .HI_SEED(P_HS[1]), .LO_SEED(P_LS[1])) dut1 (
      .clk_sys(clk_sys), .reset(reset), .start(start), .hold(hold),
      .cfg_hi_len(cfg_hi_len), .cfg_lo_len(cfg_lo_len), .cfg_num_frames(cfg_num_frames),
      .tx(bus1), .busy(busy_s[1]), .done(done_s[1]));

   xmit_traffic_gen #(.HI_PER_LO(P_HPL[2]), .IFG(P_IFG[2]), .HI_SEED(P_HS[2]), .LO_SEED(P_LS[2])) dut2 (
      .clk_sys(clk_sys), .reset(reset), .start(start), .hold(hold),
      .cfg_hi_len(cfg_hi_len), .cfg_lo_len(cfg_lo_len), .cfg_num_frames(cfg_num_frames),
      .tx(bus2), .busy(busy_s[2]), .done(done_s[2]));

   // Reference model state, one slot per instance.
   bit         run_m     [N];
   bit         pend_m    [N];
   int         frames_m  [N];
   int         body_m    [N];
   int         gap_m     [N];
   int         dv_cnt_m  [N];
   int         dv_exp_m  [N];
   int         hi_len_m  [N];
   int         lo_len_m  [N];
   int         num_m     [N];
   logic [7:0] hi_next_m [N];
   logic [7:0] lo_next_m [N];
   logic [7:0] cur_data_m[N];
   bit         cur_hp_m  [N];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic string tk(input string s, input int k);
      return $sformatf("%s@dut%0d", s, k);
   endfunction

   // Frame i of a run is hi unless it is the (HI_PER_LO+1)-th of its group.
   function automatic bit is_hi(input int k, input int i);
      return (P_HPL[k] > 0) && ((i % (P_HPL[k] + 1)) < P_HPL[k]);
   endfunction

   task automatic frame_end(input int k);
      frames_m[k]++;
      if (cur_hp_m[k]) hi_next_m[k] = hi_next_m[k] + 8'd1;
      else             lo_next_m[k] = lo_next_m[k] + 8'd1;
      gap_m[k] = 0;
      if (num_m[k] != 0 && frames_m[k] == num_m[k]) pend_m[k] = 1'b1;
   endtask

   // Compare one instance's outputs for the cycle following the latest rising edge.
   task automatic step(input int k, input logic fv, input logic dv, input logic [23:0] ctrl,
                       input logic [7:0] data, input logic hp, input logic bsy, input logic dn);
      bit         ready;
      bit         h;
      int         len;
      logic [11:0] l12;
      logic [7:0] exp_data;
      if (reset) begin
         check(tk("reset_outputs", k), {fv, dv, ctrl, data, hp, bsy, dn}, 64'd0);
         run_m[k]     = 1'b0;
         pend_m[k]    = 1'b0;
         body_m[k]    = 0;
         hi_next_m[k] = P_HS[k];
         lo_next_m[k] = P_LS[k];
         return;
      end
      if (!run_m[k] && start) begin
         run_m[k]    = 1'b1;
         frames_m[k] = 0;
         gap_m[k]    = P_IFG[k];
         hi_len_m[k] = int'(cfg_hi_len);
         lo_len_m[k] = int'(cfg_lo_len);
         num_m[k]    = int'(cfg_num_frames);
         dv_cnt_m[k] = 0;
         dv_exp_m[k] = 0;
         for (int i = 0; i < num_m[k]; i++) begin
            len = is_hi(k, i) ? hi_len_m[k] : lo_len_m[k];
            dv_exp_m[k] += (len == 0) ? 1 : len;
         end
      end
      if (pend_m[k]) begin
         check(tk("done_pulse", k), dn, 1'b1);
         check(tk("run_data_cycles", k), dv_cnt_m[k], dv_exp_m[k]);
         run_m[k]  = 1'b0;
         pend_m[k] = 1'b0;
      end else begin
         check(tk("done_quiet", k), dn, 1'b0);
      end
      check(tk("busy", k), bsy, run_m[k]);
      if (body_m[k] > 0) begin
         check(tk("body_strobes", k), {fv, dv, ctrl}, {1'b0, 1'b1, 24'd0});
         check(tk("body_payload", k), {hp, data}, {cur_hp_m[k], cur_data_m[k]});
         body_m[k]--;
         if (body_m[k] == 0) frame_end(k);
      end else begin
         ready = run_m[k] && (gap_m[k] >= P_IFG[k]) && !hold;
         check(tk("frame_valid", k), fv, ready);
         if (ready) begin
            h        = is_hi(k, frames_m[k]);
            len      = h ? hi_len_m[k] : lo_len_m[k];
            l12      = len[11:0];
            exp_data = h ? hi_next_m[k] : lo_next_m[k];
            check(tk("hdr_ctrl", k), {dv, ctrl}, {1'b1, l12, l12});
            check(tk("hdr_payload", k), {hp, data}, {h, exp_data});
            cur_data_m[k] = exp_data;
            cur_hp_m[k]   = h;
            body_m[k]     = ((len == 0) ? 1 : len) - 1;
            if (body_m[k] == 0) frame_end(k);
         end else begin
            check(tk("gap_strobes", k), {dv, ctrl}, 64'd0);
            gap_m[k]++;
         end
      end
      if (dv === 1'b1) dv_cnt_m[k]++;
   endtask

   task automatic tick();
      @(negedge clk_sys);
      step(0, bus0.f_rec_frame_valid, bus0.f_rec_data_valid, bus0.f_ctrl_in, bus0.f_data_in,
           bus0.f_hi_priority, busy_s[0], done_s[0]);
      step(1, bus1.f_rec_frame_valid, bus1.f_rec_data_valid, bus1.f_ctrl_in, bus1.f_data_in,
           bus1.f_hi_priority, busy_s[1], done_s[1]);
      step(2, bus2.f_rec_frame_valid, bus2.f_rec_data_valid, bus2.f_ctrl_in, bus2.f_data_in,
           bus2.f_hi_priority, busy_s[2], done_s[2]);
   endtask

   task automatic launch(input int hi, input int lo, input int num);
      cfg_hi_len     = 12'(hi);
      cfg_lo_len     = 12'(lo);
      cfg_num_frames = 16'(num);
      start          = 1'b1;
      tick();
      start          = 1'b0;
   endtask

   // Run until every instance is idle; optional hold jitter, config churn and ignored starts.
   task automatic run_until_idle(input int budget, input int hold_pct, input bit noise);
      int cyc = 0;
      while ((run_m[0] || run_m[1] || run_m[2]) && cyc < budget) begin
         if (noise) begin
            cfg_hi_len     = 12'($urandom_range(0, 4095));
            cfg_lo_len     = 12'($urandom_range(0, 4095));
            cfg_num_frames = 16'($urandom_range(0, 65535));
            start = run_m[0] && run_m[1] && run_m[2] && ($urandom_range(0, 19) == 0);
         end
         hold = ($urandom_range(0, 99) < hold_pct);
         tick();
         cyc++;
      end
      start = 1'b0;
      hold  = 1'b0;
      check("run_completes", {run_m[0], run_m[1], run_m[2]}, 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      n_checks = 0;
      n_pass   = 0;
      reset = 1'b1; start = 1'b0; hold = 1'b0;
      cfg_hi_len = '0; cfg_lo_len = '0; cfg_num_frames = '0;
      for (int k = 0; k < N; k++) begin
         run_m[k] = 1'b0; pend_m[k] = 1'b0; body_m[k] = 0; gap_m[k] = 0;
         hi_next_m[k] = P_HS[k]; lo_next_m[k] = P_LS[k];
      end
      @(posedge clk_sys);
      repeat (3) tick();
      reset = 1'b0;
      repeat (2) tick();

      // Zero-length hi frames, short back-to-back lo frames, hi payload wrap.
      launch(0, 4, 3);
      run_until_idle(200, 0, 1'b0);

      // Reference run with mid-run config churn and ignored start pulses.
      launch(512, 64, 11);
      run_until_idle(20000, 0, 1'b1);

      // Start while held, then random hold during and between frames.
      hold = 1'b1;
      launch(9, 5, 6);
      run_until_idle(3000, 30, 1'b1);

      for (int r = 0; r < 6; r++) begin
         hold = 1'($urandom_range(0, 1));
         launch(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20)),
                int'($urandom_range(0, 10)), int'($urandom_range(1, 8)));
         run_until_idle(3000, 30, 1'b1);
      end

      // Free-running run, then reset while instance 0 is inside a frame body.
      hold = 1'b0;
      launch(7, 3, 0);
      repeat (150) begin
         hold = ($urandom_range(0, 99) < 20);
         tick();
      end
      hold = 1'b0;
      check("free_run_still_busy", busy_s[0], 1'b1);
      w = 0;
      while (body_m[0] == 0 && w < 100) begin
         tick();
         w++;
      end
      check("reached_body_before_reset", bus0.f_rec_data_valid & ~bus0.f_rec_frame_valid, 1'b1);
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      repeat (5) tick();

      // Fresh start after reset begins again from the seed payloads.
      launch(5, 2, 2);
      run_until_idle(500, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/xmit_traffic_gen.md
XMIT_TRAFFIC_GEN -- requirements
Module: xmit_traffic_gen

Interface
REQ-001 Parameter DATA_W, default 8, payload byte width.
REQ-002 Parameter LEN_W, default 12, frame-length field width; ctrl word is 2*LEN_W bits.
REQ-003 Parameter HI_PER_LO, default 10, hi-priority frames emitted before each lo-priority frame; 0 means lo only.
REQ-004 Parameter IFG, default 1, idle cycles between frames; 0 means back-to-back.
REQ-005 Parameter HI_SEED, default 8'hF0, first hi-frame payload value.
REQ-006 Parameter LO_SEED, default 8'h00, first lo-frame payload value.
REQ-007 clk_sys  in  1  single system clock, all logic rising-edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  level; sampled in IDLE, begins a run.
REQ-010 hold  in  1  level; blocks the start of a new frame, never truncates one.
REQ-011 cfg_hi_len / cfg_lo_len  in  LEN_W each  hi/lo frame length in cycles.
REQ-012 cfg_num_frames  in  16  frames per run; 0 = free-running.
REQ-013 f_data_in  out  DATA_W  payload byte to transmit subsystem.
REQ-014 f_ctrl_in  out  2*LEN_W  control block {len,len}, non-zero only on header cycle.
REQ-015 f_rec_data_valid / f_rec_frame_valid / f_hi_priority  out  1 each  data strobe / header strobe / class of current frame.
REQ-016 busy, done  out  1 each  run in progress / one-cycle run-complete pulse.

Function
REQ-017 All outputs SHALL be registered; states IDLE, HDR, BODY, GAP.
REQ-018 IDLE: on start=1 SHALL latch cfg_* into internal registers and go to HDR if hold=0, else wait in IDLE-armed until hold=0; busy=1 from the cycle after start.
REQ-019 HDR (1 cycle): f_rec_frame_valid=1, f_rec_data_valid=1, f_ctrl_in={len,len}, f_data_in=class payload, f_hi_priority=class.
REQ-020 BODY: f_rec_data_valid=1 for len-1 further cycles, f_data_in and f_hi_priority constant, f_ctrl_in=0, f_rec_frame_valid=0.
REQ-021 Latched length 0 SHALL be treated as 1 (HDR only, BODY skipped).
REQ-022 GAP: all strobes 0, f_data_in held, for IFG cycles; IFG=0 goes BODY→HDR directly.
REQ-023 After GAP, a new HDR SHALL start only when hold=0; hold asserted mid-frame has no effect until the frame ends.
REQ-024 Class sequence: HI_PER_LO hi frames, then 1 lo frame, repeating; sequence counter restarts at each run.
REQ-025 Hi payload counter SHALL start at HI_SEED, increment by 1 after each hi frame, modulo 2^DATA_W; lo counter likewise from LO_SEED.
REQ-026 Frame counter SHALL increment at each frame end; when it equals nonzero cfg_num_frames, SHALL return to IDLE, pulse done for 1 cycle, clear busy.
REQ-027 cfg_num_frames=0: run SHALL continue until reset; done never pulses.
REQ-028 start while busy SHALL be ignored; cfg_* changes mid-run SHALL be ignored.
REQ-029 Latency: start high at edge t yields f_rec_frame_valid=1 at edge t+1 (hold=0).

Reset
REQ-030 reset=1 at any edge SHALL force IDLE, all outputs 0, counters reloaded to HI_SEED/LO_SEED, frame and sequence counters 0, within that same edge, aborting any frame in progress.
REQ-031 Outputs SHALL stay 0 while reset held; first run after release requires a fresh start.

Verification
REQ-032 Defaults, cfg_hi_len=512, cfg_lo_len=64, num_frames=11, start pulse -> 10 hi frames payload F0..F9 ctrl 200200 each 512 data cycles, then 1 lo frame payload 00 ctrl 040040 64 cycles, 1-cycle gaps, done at end.
REQ-033 HI_PER_LO=0, IFG=0, lo_len=4, num_frames=3 -> 12 contiguous data-valid cycles, payloads 00,01,02, frame_valid at cycles 0,4,8.
REQ-034 hold raised mid hi frame 2 -> frame completes full length; next HDR delayed until hold=0.
REQ-035 cfg_hi_len=0 -> every hi frame one cycle, frame_valid and data_valid coincident, ctrl 000000.
REQ-036 HI_SEED=FE, num_frames=3, HI_PER_LO=5 -> hi payloads FE, FF, 00 (wrap).
REQ-037 reset asserted during BODY -> next edge all outputs 0, IDLE; restart yields payload HI_SEED again.
